dff_bank_rr_ctrl: RTL

- Shared register bank of DEPTH words × WIDTH bits, built from edge-triggered D flip-flops.
- Clears asynchronously to zero.
- Shared between NREQ requesters through a round-robin arbiter and a two-state controller.
- One request is serviced per transaction. Each request is a read, write, word-set (all ones) or word-clear.
- Sits between control agents and a common status/config register file.

---
 rtl/dff_bank_rr_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dff_bank_rr_ctrl.sv
// Shared flip-flop register bank with a round-robin arbiter and a two-state
// (IDLE/EXEC) controller. Each transaction services one requester's
// read, write, set-word or clear-word command.
module dff_bank_rr_ctrl #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [AW*NREQ-1:0]    addr,
    input  logic [WIDTH*NREQ-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e            state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     cmd_idx_q;
    logic [1:0]        cmd_op_q;
    logic [AW-1:0]     cmd_addr_q;
    logic [WIDTH-1:0]  cmd_wdata_q;
    logic [WIDTH-1:0]  bank_q [DEPTH];

    logic              win_valid;
    logic [PW-1:0]     win_idx;
    logic [NREQ-1:0]   win_onehot;
    logic [1:0]        win_op;
    logic [AW-1:0]     win_addr;
    logic [WIDTH-1:0]  win_wdata;
    logic [WIDTH-1:0]  win_rd;
    int unsigned       scan_idx;

    // Round-robin scan starting at ptr, then pick the winner's command slices.
    always_comb begin
        win_valid  = 1'b0;
        win_idx    = '0;
        scan_idx   = 0;
        win_onehot = '0;
        win_op     = OpRead;
        win_addr   = '0;
        win_wdata  = '0;
        win_rd     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_idx = (32'(ptr_q) + i) % NREQ;
            if (!win_valid && req[PW'(scan_idx)]) begin
                win_valid = 1'b1;
                win_idx   = PW'(scan_idx);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_valid && (PW'(i) == win_idx)) begin
                win_onehot[i] = 1'b1;
                win_op        = op[2*i +: 2];
                win_addr      = addr[AW*i +: AW];
                win_wdata     = wdata[WIDTH*i +: WIDTH];
            end
        end
        // Out-of-range addresses match no word and read back as zero.
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (AW'(j) == win_addr) begin
                win_rd = bank_q[j];
            end
        end
    end

    // Controller: latch the winner in IDLE, present ack/read data during EXEC.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            cmd_idx_q   <= '0;
            cmd_op_q    <= OpRead;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            gnt         <= '0;
            rdata       <= '0;
            rvalid      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        state_q     <= StExec;
                        cmd_idx_q   <= win_idx;
                        cmd_op_q    <= win_op;
                        cmd_addr_q  <= win_addr;
                        cmd_wdata_q <= win_wdata;
                        gnt         <= win_onehot;
                        busy        <= 1'b1;
                        rvalid      <= (win_op == OpRead);
                        rdata       <= (win_op == OpRead) ? win_rd : '0;
                    end else begin
                        gnt    <= '0;
                        busy   <= 1'b0;
                        rvalid <= 1'b0;
                        rdata  <= '0;
                    end
                end
                StExec: begin
                    state_q <= StIdle;
                    ptr_q   <= (cmd_idx_q == PW'(NREQ - 1)) ? '0 : cmd_idx_q + 1'b1;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    rvalid  <= 1'b0;
                    rdata   <= '0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Bank update on the closing edge of EXEC; reset clears every word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                bank_q[j] <= '0;
            end
        end else if (state_q == StExec) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (AW'(j) == cmd_addr_q) begin
                    unique case (cmd_op_q)
                        OpWrite: bank_q[j] <= cmd_wdata_q;
                        OpSet:   bank_q[j] <= '1;
                        OpClear: bank_q[j] <= '0;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
